// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative write-back data cache:
// controller state encoding, derived-width functions and address field extraction.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // A direct-mapped build still needs a 1-bit way select.
  function automatic int way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  function automatic int tag_w(input int addr_w, input int num_sets, input int words_per_line);
    return addr_w - idx_w(num_sets) - off_w(words_per_line) - 2;
  endfunction

  function automatic logic [63:0] addr_off(input logic [63:0] addr, input int off_bits);
    return (addr >> 2) & ((64'd1 << off_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_idx(input logic [63:0] addr, input int off_bits,
                                           input int idx_bits);
    return (addr >> (off_bits + 2)) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int off_bits,
                                           input int idx_bits);
    return addr >> (idx_bits + off_bits + 2);
  endfunction

endpackage

// File: rtl/cache_set_ram.sv
// Tag and line storage for all ways: whole-set asynchronous read, a word write
// port for store hits and a full-line write port for fills.
module cache_set_ram #(
  parameter int NUM_SETS = 1024,
  parameter int NUM_WAYS = 2,
  parameter int IDX_W    = 10,
  parameter int OFF_W    = 2,
  parameter int TAG_W    = 18,
  parameter int WAY_W    = 1,
  parameter int LINE_W   = 128
) (
  input  logic                       clk,
  input  logic [IDX_W-1:0]           i_idx,
  output logic [NUM_WAYS*TAG_W-1:0]  o_tags,
  output logic [NUM_WAYS*LINE_W-1:0] o_lines,
  input  logic                       i_word_we,
  input  logic [WAY_W-1:0]           i_word_way,
  input  logic [OFF_W-1:0]           i_word_off,
  input  logic [31:0]                i_word_data,
  input  logic                       i_line_we,
  input  logic [WAY_W-1:0]           i_line_way,
  input  logic [TAG_W-1:0]           i_line_tag,
  input  logic [LINE_W-1:0]          i_line_data
);

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    logic [TAG_W-1:0]  r_tag_mem  [NUM_SETS];
    logic [LINE_W-1:0] r_line_mem [NUM_SETS];

    // A fill replaces the whole line, so it takes priority over a word write.
    always_ff @(posedge clk) begin
      if (i_line_we && (i_line_way == WAY_W'(gi))) begin
        r_tag_mem[i_idx]  <= i_line_tag;
        r_line_mem[i_idx] <= i_line_data;
      end else if (i_word_we && (i_word_way == WAY_W'(gi))) begin
        r_line_mem[i_idx][{i_word_off, 5'b0} +: 32] <= i_word_data;
      end
    end

    assign o_tags[gi*TAG_W +: TAG_W]    = r_tag_mem[i_idx];
    assign o_lines[gi*LINE_W +: LINE_W] = r_line_mem[i_idx];
  end

endmodule

// File: rtl/cache_wb_assoc.sv
// N-way set-associative write-back, write-allocate data cache with round-robin
// replacement and a req/ack line handshake. Define CACHE_STATS_EN for hit/miss/wb counters.
module cache_wb_assoc
  import cache_pkg::*;
#(
  parameter int NUM_SETS       = 1024,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  output logic [31:0]                 cpu_rdata,
  output logic                        cpu_ready,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [32*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [32*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                        mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                 stat_hits,
  output logic [31:0]                 stat_misses,
  output logic [31:0]                 stat_wbs
`endif
);

  localparam int OFF_W  = off_w(WORDS_PER_LINE);
  localparam int IDX_W  = idx_w(NUM_SETS);
  localparam int TAG_W  = tag_w(ADDR_W, NUM_SETS, WORDS_PER_LINE);
  localparam int WAY_W  = way_w(NUM_WAYS);
  localparam int LINE_W = 32 * WORDS_PER_LINE;
  localparam logic [OFF_W+1:0] LO_ZERO = '0;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;

  assign w_off = OFF_W'(addr_off(64'(cpu_addr), OFF_W));
  assign w_idx = IDX_W'(addr_idx(64'(cpu_addr), OFF_W, IDX_W));
  assign w_tag = TAG_W'(addr_tag(64'(cpu_addr), OFF_W, IDX_W));

  state_t              r_state;
  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
  logic [WAY_W-1:0]    r_rr    [NUM_SETS];
  logic [IDX_W-1:0]    r_idx;
  logic [TAG_W-1:0]    r_tag;
  logic [WAY_W-1:0]    r_victim;
  logic                r_victim_rr;
  logic                r_refill;

  logic [IDX_W-1:0]           w_ram_idx;
  logic [NUM_WAYS*TAG_W-1:0]  w_tags;
  logic [NUM_WAYS*LINE_W-1:0] w_lines;
  logic [NUM_WAYS-1:0]        w_hit_vec;
  logic                       w_hit;
  logic [WAY_W-1:0]           w_hit_way;
  logic [LINE_W-1:0]          w_hit_line;
  logic [31:0]                w_hit_word;
  logic [WAY_W-1:0]           w_victim;
  logic                       w_victim_rr;
  logic [TAG_W-1:0]           w_victim_tag;
  logic [LINE_W-1:0]          w_victim_line;
  logic                       w_victim_dirty;
  logic                       w_word_we;
  logic                       w_line_we;

  // Lookups use the live address; outstanding misses use the latched index.
  assign w_ram_idx = (r_state == IDLE) ? w_idx : r_idx;

  cache_set_ram #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS),
    .IDX_W    (IDX_W),
    .OFF_W    (OFF_W),
    .TAG_W    (TAG_W),
    .WAY_W    (WAY_W),
    .LINE_W   (LINE_W)
  ) u_ram (
    .clk         (clk),
    .i_idx       (w_ram_idx),
    .o_tags      (w_tags),
    .o_lines     (w_lines),
    .i_word_we   (w_word_we),
    .i_word_way  (w_hit_way),
    .i_word_off  (w_off),
    .i_word_data (cpu_wdata),
    .i_line_we   (w_line_we),
    .i_line_way  (r_victim),
    .i_line_tag  (r_tag),
    .i_line_data (mem_rdata)
  );

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_hit
    assign w_hit_vec[gi] = r_valid[w_idx][gi] && (w_tags[gi*TAG_W +: TAG_W] == w_tag);
  end

  always_comb begin
    w_hit         = |w_hit_vec;
    w_hit_way     = '0;
    w_hit_line    = '0;
    w_victim      = r_rr[w_idx];
    w_victim_rr   = 1'b1;
    w_victim_tag  = '0;
    w_victim_line = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (w_hit_vec[i]) begin
        w_hit_way  = WAY_W'(i);
        w_hit_line = w_lines[i*LINE_W +: LINE_W];
      end
    end
    // Scan downwards so the lowest-numbered invalid way wins.
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!r_valid[w_idx][i]) begin
        w_victim    = WAY_W'(i);
        w_victim_rr = 1'b0;
      end
    end
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (w_victim == WAY_W'(i)) begin
        w_victim_tag  = w_tags[i*TAG_W +: TAG_W];
        w_victim_line = w_lines[i*LINE_W +: LINE_W];
      end
    end
  end

  assign w_hit_word     = w_hit_line[{w_off, 5'b0} +: 32];
  assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
  assign w_word_we      = (r_state == IDLE) && cpu_req && cpu_we && w_hit;
  assign w_line_we      = (r_state == FILL) && mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
      r_idx       <= '0;
      r_tag       <= '0;
      r_victim    <= '0;
      r_victim_rr <= 1'b0;
      r_refill    <= 1'b0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
`ifdef CACHE_STATS_EN
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbs    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_refill <= 1'b0;
          if (cpu_req) begin
            if (w_hit) begin
              r_state   <= RESP;
              cpu_ready <= 1'b1;
              if (cpu_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
              else        cpu_rdata <= w_hit_word;
`ifdef CACHE_STATS_EN
              if (!r_refill) stat_hits <= stat_hits + 32'd1;
`endif
            end else begin
              r_idx       <= w_idx;
              r_tag       <= w_tag;
              r_victim    <= w_victim;
              r_victim_rr <= w_victim_rr;
              mem_req     <= 1'b1;
              if (w_victim_dirty) begin
                r_state   <= WB;
                mem_we    <= 1'b1;
                mem_addr  <= {w_victim_tag, w_idx, LO_ZERO};
                mem_wdata <= w_victim_line;
              end else begin
                r_state   <= FILL;
                mem_we    <= 1'b0;
                mem_addr  <= {w_tag, w_idx, LO_ZERO};
              end
`ifdef CACHE_STATS_EN
              stat_misses <= stat_misses + 32'd1;
`endif
            end
          end
        end
        WB: begin
          if (mem_ack) begin
            r_dirty[r_idx][r_victim] <= 1'b0;
            r_state  <= FILL;
            mem_we   <= 1'b0;
            mem_addr <= {r_tag, r_idx, LO_ZERO};
`ifdef CACHE_STATS_EN
            stat_wbs <= stat_wbs + 32'd1;
`endif
          end
        end
        FILL: begin
          if (mem_ack) begin
            r_valid[r_idx][r_victim] <= 1'b1;
            r_dirty[r_idx][r_victim] <= 1'b0;
            // Filling an invalid way leaves the round-robin pointer alone.
            if (r_victim_rr)
              r_rr[r_idx] <= (r_rr[r_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : r_rr[r_idx] + 1'b1;
            mem_req  <= 1'b0;
            r_refill <= 1'b1;
            r_state  <= IDLE;
          end
        end
        RESP: begin
          cpu_ready <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_wb_assoc.sv
// Directed bench for cache_wb_assoc (default 2-way, 4-word lines) with a
// behavioural line memory that logs every writeback and fill.
module tb_cache_wb_assoc;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0]       stat_hits;
  logic [31:0]       stat_misses;
  logic [31:0]       stat_wbs;
`endif

  cache_wb_assoc #(
    .NUM_SETS       (1024),
    .NUM_WAYS       (2),
    .WORDS_PER_LINE (4),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_wbs    (stat_wbs)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  int                n_fill = 0;
  int                n_wb   = 0;
  logic [31:0]       last_fill_addr = '0;
  logic [31:0]       last_wb_addr   = '0;
  logic [LINE_W-1:0] last_wb_data   = '0;
  int                ack_delay      = 0;

  logic [31:0] mem_words [logic [31:0]];

  // Untouched memory holds 0x1000_0000 + byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'h1000_0000 + a;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory side: accept a request, wait ack_delay cycles, pulse mem_ack.
  initial begin
    logic              req_we;
    logic [31:0]       req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              aborted;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !reset) begin
        req_we    = mem_we;
        req_addr  = mem_addr;
        req_wdata = mem_wdata;
        aborted   = 1'b0;
        for (int k = 0; k < ack_delay; k++) begin
          @(posedge clk); #1;
          if (reset) begin
            aborted = 1'b1;
            break;
          end
        end
        if (aborted) begin
          $display("mem  abort addr=%h", req_addr);
        end else begin
          if (req_we) begin
            for (int w = 0; w < 4; w++) mem_words[req_addr + 32'(4*w)] = req_wdata[w*32 +: 32];
            n_wb++;
            last_wb_addr = req_addr;
            last_wb_data = req_wdata;
            $display("mem  wb   addr=%h data=%h", req_addr, req_wdata);
          end else begin
            for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = mem_word(req_addr + 32'(4*w));
            n_fill++;
            last_fill_addr = req_addr;
            $display("mem  fill addr=%h data=%h", req_addr, mem_rdata);
          end
          mem_ack = 1'b1;
          @(posedge clk); #1;
          mem_ack = 1'b0;
        end
      end
    end
  end

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int cycles);
    logic seen;
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cycles    = 0;
    rdata     = '0;
    seen      = 1'b0;
    while (cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (cpu_ready) begin
        rdata = cpu_rdata;
        seen  = 1'b1;
        break;
      end
    end
    cpu_req = 1'b0;
    check_eq("ready_seen", 128'(seen), 128'd1);
    $display("cpu  we=%0b addr=%h wdata=%h rdata=%h cycles=%0d", we, addr, wdata, rdata, cycles);
  endtask

  task automatic acc(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_cycles);
    logic [31:0] rd;
    int          cyc;
    do_access(we, addr, wdata, rd, cyc);
    if (!we) check_eq({tag, "_rdata"}, 128'(rd), 128'(exp_rdata));
    check_eq({tag, "_cycles"}, 128'(cyc), 128'(exp_cycles));
  endtask

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_cpu_ready", 128'(cpu_ready), 128'd0);
    check_eq("rst_cpu_rdata", 128'(cpu_rdata), 128'd0);
    check_eq("rst_mem_req",   128'(mem_req),   128'd0);
    check_eq("rst_mem_we",    128'(mem_we),    128'd0);
    check_eq("rst_mem_addr",  128'(mem_addr),  128'd0);
    check_eq("rst_mem_wdata", 128'(mem_wdata), 128'd0);

    // Cold load, memory answers after a 2-cycle wait.
    ack_delay = 2;
    acc("cold_load", 1'b0, 32'h40, 32'h0, 32'h1000_0040, 5);
    check_eq("cold_fills", 128'(n_fill), 128'd1);
    check_eq("cold_fill_addr", 128'(last_fill_addr), 128'h40);
    check_eq("cold_req_low", 128'(mem_req), 128'd0);
    ack_delay = 0;

    // Store hit then load hit on the same line; memory untouched.
    acc("st_hit", 1'b1, 32'h44, 32'hDEAD_BEEF, 32'h0, 1);
    acc("ld_hit", 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 1);
    check_eq("hit_no_mem", 128'(n_fill + n_wb), 128'd1);

    // Second way fills invalid way1; dirty way0 is the rr victim for 0x8040.
    acc("fill_4040", 1'b0, 32'h4040, 32'h0, 32'h1000_4040, 3);
    acc("st_40", 1'b1, 32'h40, 32'h1234_5678, 32'h0, 1);
    acc("dirty_miss", 1'b0, 32'h8040, 32'h0, 32'h1000_8040, 5);
    check_eq("wb_count", 128'(n_wb), 128'd1);
    check_eq("wb_addr", 128'(last_wb_addr), 128'h40);
    check_eq("wb_data", last_wb_data, 128'h1000_004C_1000_0048_DEAD_BEEF_1234_5678);
    check_eq("wb_fill_addr", 128'(last_fill_addr), 128'h8040);

    // Round-robin continues way1, way0, way1 with clean victims.
    acc("rr_c040", 1'b0, 32'hC040, 32'h0, 32'h1000_C040, 3);
    acc("rr_4040", 1'b0, 32'h4040, 32'h0, 32'h1000_4040, 3);
    acc("rr_40",   1'b0, 32'h40,   32'h0, 32'h1234_5678, 3);
    check_eq("rr_no_wb", 128'(n_wb), 128'd1);
    acc("rr_4040_hit", 1'b0, 32'h4040, 32'h0, 32'h1000_4040, 1);
    acc("rr_44_hit",   1'b0, 32'h44,   32'h0, 32'hDEAD_BEEF, 1);
    acc("rr_c040_gone", 1'b0, 32'hC040, 32'h0, 32'h1000_C040, 3);
    check_eq("rr_fills", 128'(n_fill), 128'd7);

    // Reset in the middle of a fill drops mem_req immediately.
    ack_delay = 10;
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check_eq("fill_req_up", 128'(mem_req), 128'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort_mem_req", 128'(mem_req), 128'd0);
    check_eq("abort_ready", 128'(cpu_ready), 128'd0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    ack_delay = 0;
    acc("post_rst_40", 1'b0, 32'h40, 32'h0, 32'h1234_5678, 3);
    check_eq("post_rst_fills", 128'(n_fill), 128'd8);

    // All words of one line: one fill then hits with the right word select.
    acc("line_w0", 1'b0, 32'h200, 32'h0, 32'h1000_0200, 3);
    acc("line_w1", 1'b0, 32'h204, 32'h0, 32'h1000_0204, 1);
    acc("line_w2", 1'b0, 32'h208, 32'h0, 32'h1000_0208, 1);
    acc("line_w3", 1'b0, 32'h20C, 32'h0, 32'h1000_020C, 1);
    check_eq("line_fills", 128'(n_fill), 128'd9);

`ifdef CACHE_STATS_EN
    check_eq("stat_hits",   128'(stat_hits),   128'd3);
    check_eq("stat_misses", 128'(stat_misses), 128'd2);
    check_eq("stat_wbs",    128'(stat_wbs),    128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
